// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA pixel fetch has absolute priority,
// capture writes go through a small FIFO, and a zero-fill walks the whole buffer.
module fb_port_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int WQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  posX,
    input  logic [8:0]  posY,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [11:0] wr_data,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        addr_err,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic [11:0] pixel_out
);
    localparam int unsigned FB_SIZE   = FB_W * FB_H;
    localparam logic [31:0] FB_W_BITS = 32'(FB_W);
    localparam int          PW        = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int          CW        = $clog2(WQ_DEPTH + 1);
    localparam logic [14:0] CLR_LAST  = 15'(FB_SIZE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state_q, state_d;

    logic        rd_slot;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [14:0] row_terms [15];
    logic [14:0] rd_addr;

    assign rd_slot = (posX < 10'd640) && (posY < 9'd480) && (posX[SCALE_SH-1:0] == '0);
    assign row     = posY >> SCALE_SH;
    assign col     = posX >> SCALE_SH;

    // row * FB_W as a sum of shifted copies, one per set bit of FB_W
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_terms
            if (FB_W_BITS[gi]) begin : g_on
                assign row_terms[gi] = 15'({23'd0, row} << gi);
            end else begin : g_off
                assign row_terms[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        rd_addr = {5'd0, col};
        for (int k = 0; k < 15; k++) begin
            rd_addr = rd_addr + row_terms[k];
        end
    end

    logic [14:0]   wq_addr_q [WQ_DEPTH];
    logic [11:0]   wq_data_q [WQ_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          wq_empty, wq_full, push, pop, head_bad;

    assign wq_empty = (count_q == '0);
    assign wq_full  = (count_q == CW'(WQ_DEPTH));
    assign wr_ready = !wq_full && (state_q == IDLE);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == IDLE) && !rd_slot && !wq_empty;
    assign head_bad = ({17'd0, wq_addr_q[head_q]} >= FB_SIZE);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(WQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wq_addr_q[tail_q] <= wr_addr;
                wq_data_q[tail_q] <= wr_data;
                tail_q            <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    logic [14:0] clr_cnt_q, clr_cnt_d, addr_hold_q;
    logic [11:0] wdata_hold_q, pix_q;
    logic        rd_slot_q, addr_err_q;

    // Port mux is combinational so the RAM sees the fetch address in the slot cycle itself
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_addr  = addr_hold_q;
        mem_wdata = wdata_hold_q;
        if (rd_slot) begin
            mem_addr = rd_addr;
        end else if (pop) begin
            if (!head_bad) begin
                mem_we    = 1'b1;
                mem_addr  = wq_addr_q[head_q];
                mem_wdata = wq_data_q[head_q];
            end
        end else if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = '0;
            if (clr_cnt_q == CLR_LAST) begin
                clr_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                clr_cnt_d = clr_cnt_q + 15'd1;
            end
        end
        if ((state_q == IDLE) && clear_req) begin
            state_d = CLEAR;
        end
        if (rst) begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            pix_q        <= '0;
            rd_slot_q    <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            addr_hold_q  <= mem_addr;
            wdata_hold_q <= mem_wdata;
            rd_slot_q    <= rd_slot;
            if (rd_slot_q) begin
                pix_q <= mem_rdata;
            end
            if (pop && head_bad) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign addr_err   = addr_err_q;
    assign pixel_out  = pix_q;

endmodule
